// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that drives a 3-to-8 decoder select ({A,B,C}) and enable (en).
// Optional grant time limit: define DEC_ARB_QUANTUM_EN to cap each grant at QUANTUM cycles.
module decoder_rr_arbiter #(
  parameter int QUANTUM = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       en,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  if (QUANTUM < 1 || QUANTUM > 255) begin : g_bad_quantum
    $error("decoder_rr_arbiter: QUANTUM must be in 1..255");
  end

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic [2:0] winner;
  logic       quantum_hit;

`ifdef DEC_ARB_QUANTUM_EN
  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts completed ACTIVE cycles of the current grant, so this is the last one.
  assign quantum_hit = (cnt_q >= 8'(QUANTUM - 1));
`else
  assign quantum_hit = 1'b0;
`endif

  // First set request at or after ptr, wrapping 7 -> 0.
  always_comb begin
    logic found;
    logic [2:0] idx;
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    en_d    = en_q;
    busy_d  = busy_q;
`ifdef DEC_ARB_QUANTUM_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ACTIVE: begin
`ifdef DEC_ARB_QUANTUM_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (done || !req[sel_q] || quantum_hit) begin
          state_d = GAP;
          en_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        // Select only moves here, while en is low.
        if (req != 8'd0) begin
          state_d = ACTIVE;
          sel_d   = winner;
          ptr_d   = winner + 3'd1;
          en_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef DEC_ARB_QUANTUM_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DEC_ARB_QUANTUM_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
`ifdef DEC_ARB_QUANTUM_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign A    = sel_q[2];
  assign B    = sel_q[1];
  assign C    = sel_q[0];
  assign en   = en_q;
  assign busy = busy_q;

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter: QUANTUM, 16, maximum number of cycles one grant may hold sel_en high (used only when DEC_ARB_QUANTUM_EN is defined; legal 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  8  request vector; req[i] asks for decoder output Yi.
REQ-005 Port: done  input  1  current owner releases the grant; sampled only in ACTIVE.
REQ-006 Port: A  output  1  decoder select MSB; granted index = {A,B,C}.
REQ-007 Port: B  output  1  decoder select middle bit.
REQ-008 Port: C  output  1  decoder select LSB.
REQ-009 Port: en  output  1  decoder enable; high only while a grant is active.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement three states: IDLE, ACTIVE, GAP; all outputs registered.
REQ-012 IDLE/GAP: at the edge where req != 0, the block SHALL load {A,B,C} with the winner and enter ACTIVE, so en=1 in the following cycle (1-cycle latency).
REQ-013 IDLE/GAP with req == 0: GAP SHALL go to IDLE; IDLE SHALL stay in IDLE; {A,B,C} held.
REQ-014 Arbitration SHALL be round-robin: search starts at ptr, ascending, wrapping 7->0; first set req bit wins.
REQ-015 ptr SHALL become (winner+1) mod 8 on every grant; 7 wraps to 0.
REQ-016 ACTIVE exits to GAP at the edge where done=1 or req[{A,B,C}]=0 (or quantum expiry, REQ-024); en=0 in GAP.
REQ-017 {A,B,C} SHALL change only on edges where en is currently 0 (break-before-make; no select change while enabled).
REQ-018 Consecutive grants SHALL be separated by exactly one en=0 cycle (GAP) when requests are pending.
REQ-019 done asserted in IDLE or GAP SHALL be ignored.
REQ-020 A sole persistent requester SHALL be re-granted after each GAP cycle.

Reset
REQ-021 On rst_n=0, immediately and independent of clk: state=IDLE, en=0, busy=0, A=B=C=0, ptr=0, quantum counter=0.
REQ-022 Reset asserted during ACTIVE SHALL drop en within the same cycle (asynchronously), no GAP cycle.
REQ-023 After rst_n deassertion, first arbitration SHALL occur at the first rising edge with rst_n=1.

Configuration
REQ-024 With DEC_ARB_QUANTUM_EN defined: an 8-bit counter SHALL clear on ACTIVE entry, increment each ACTIVE cycle, and force ACTIVE->GAP after en has been high QUANTUM cycles, even if done=0 and request held.
REQ-025 Without DEC_ARB_QUANTUM_EN: no counter, QUANTUM ignored; ACTIVE lasts until done=1 or owner req drops.

Verification
REQ-026 Reset: rst_n=0 with req=8'hFF -> en=0, busy=0, {A,B,C}=3'b000; on release, req=8'h01 -> en=1, {A,B,C}=0 one cycle later.
REQ-027 Rotation: req=8'hFF, done pulsed each ACTIVE cycle -> grant order 0,1,2,...,7,0 with one en=0 cycle between grants.
REQ-028 Wrap/skip: ptr=6, req=8'b0000_0101 -> winner 0, then winner 2, then 0 again.
REQ-029 Release by drop: owner 3 holds 5 cycles then req[3]=0 -> en falls next edge, GAP 1 cycle, idle with busy=0 if req=0.
REQ-030 Quantum (macro defined, QUANTUM=4): req=8'h10 held, done=0 -> en high exactly 4 cycles, low 1, high 4, repeating; without macro en stays high.
REQ-031 Async reset mid-grant: rst_n pulled low between edges during ACTIVE -> en=0 before next edge, state IDLE.
